// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the memory port arbiter.
//               Defines the arbiter FSM state encoding, the transaction
//               owner encoding and the request-vector bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2,
        ARB_RESP      = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } arb_owner_t;

    // Bit positions inside the two-entry request vector.
    localparam int c_REQ_FETCH = 0;
    localparam int c_REQ_DATA  = 1;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the fetch requester, data requester and memory-side
//               handshake signals of the memory port arbiter.
//               master : arbiter view (drives grants, responses, memory bus)
//               slave  : environment view (requesters and memory model)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic                  f_req_i;
    logic [ADDR_W-1:0]     f_addr_i;
    logic                  f_gnt_o;
    logic                  f_rvalid_o;
    logic [DATA_W-1:0]     f_rdata_o;
    logic                  f_err_o;
    // Load/store requester
    logic                  d_req_i;
    logic [ADDR_W-1:0]     d_addr_i;
    logic                  d_we_i;
    logic [DATA_W-1:0]     d_wdata_i;
    logic [DATA_W/8-1:0]   d_wstrb_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_W-1:0]     d_rdata_o;
    logic                  d_err_o;
    // Memory side
    logic                  mem_valid_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic                  mem_we_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  mem_ready_i;
    logic                  mem_rvalid_i;
    logic [DATA_W-1:0]     mem_rdata_i;
    // Status
    logic                  busy_o;

    modport master (
        input  f_req_i, f_addr_i,
        input  d_req_i, d_addr_i, d_we_i, d_wdata_i, d_wstrb_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
        output busy_o
    );

    modport slave (
        output f_req_i, f_addr_i,
        output d_req_i, d_addr_i, d_we_i, d_wdata_i, d_wstrb_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  f_gnt_o, f_rvalid_o, f_rdata_o, f_err_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_valid_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_wstrb_o,
        input  busy_o
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin pick.
//               req[0] = fetch, req[1] = data.
//               When both request, the one that did not own the previous
//               transaction wins; a lone requester always wins.
// Ports       : req        - request vector
//               last_owner - owner of the most recent grant
//               winner     - selected requester (valid when any = 1)
//               any        - at least one request pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  wire logic [1:0] req,
    input  arb_owner_t      last_owner,
    output arb_owner_t      winner,
    output logic            any
);

    always_comb begin
        winner = OWNER_FETCH;
        if (req[c_REQ_FETCH] && req[c_REQ_DATA]) begin
            winner = (last_owner == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
        end else if (req[c_REQ_DATA]) begin
            winner = OWNER_DATA;
        end
    end

    assign any = |req;

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between the instruction-fetch and the
//               load/store requesters. One transaction outstanding at a time,
//               round-robin selection, latched request fields, memory
//               valid/ready handshake, response (or timeout error) routed
//               back to the owning requester.
// Ports       : clk_i   - clock, all logic on posedge
//               reset_i - synchronous active-high reset
//               bus     - requester / memory / status signals (master view)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic           clk_i,
    input  wire logic           reset_i,
    mem_port_arbiter_if.master  bus
);

    localparam int          c_STRB_W  = DATA_W / 8;
    localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT_CYCLES);

    arb_state_t             r_state;
    arb_owner_t             r_last_owner;
    arb_owner_t             r_owner;
    logic [ADDR_W-1:0]      r_addr;
    logic                   r_we;
    logic [DATA_W-1:0]      r_wdata;
    logic [c_STRB_W-1:0]    r_wstrb;
    logic [7:0]             r_cnt;
    logic                   r_f_rvalid;
    logic [DATA_W-1:0]      r_f_rdata;
    logic                   r_f_err;
    logic                   r_d_rvalid;
    logic [DATA_W-1:0]      r_d_rdata;
    logic                   r_d_err;

    logic [1:0]             w_req;
    arb_owner_t             w_winner;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_timeout;
    logic                   w_resp_fire;
    logic [DATA_W-1:0]      w_resp_data;
    logic                   w_resp_err;

    assign w_req = {bus.d_req_i, bus.f_req_i};

    rr_arbiter2 u_rr (
        .req        (w_req),
        .last_owner (r_last_owner),
        .winner     (w_winner),
        .any        (w_any)
    );

    // Grant is decided in the same cycle the request is seen in IDLE, so the
    // requester can release its request on the following edge.
    assign w_grant = (r_state == ARB_IDLE) && w_any && !reset_i;

    // The counter value r_cnt is the number of WAIT_RESP cycles already
    // completed; the timeout fires in the cycle whose increment would make the
    // counter reach TIMEOUT_CYCLES-1. Written as a >= so that
    // TIMEOUT_CYCLES = 1 still terminates on the first WAIT_RESP cycle.
    assign w_timeout = ({24'd0, r_cnt} + 32'd2) >= c_TIMEOUT;

    // A real response wins over a coincident timeout.
    assign w_resp_fire = (r_state == ARB_WAIT_RESP) && (bus.mem_rvalid_i || w_timeout);
    assign w_resp_data = bus.mem_rvalid_i ? bus.mem_rdata_i : '0;
    assign w_resp_err  = !bus.mem_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= ARB_IDLE;
            r_last_owner <= OWNER_DATA;
            r_owner      <= OWNER_FETCH;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
            r_f_rvalid   <= 1'b0;
            r_f_rdata    <= '0;
            r_f_err      <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_d_rdata    <= '0;
            r_d_err      <= 1'b0;
        end else begin
            r_f_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        if (w_winner == OWNER_FETCH) begin
                            r_addr  <= bus.f_addr_i;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_wstrb <= '1;
                        end else begin
                            r_addr  <= bus.d_addr_i;
                            r_we    <= bus.d_we_i;
                            r_wdata <= bus.d_wdata_i;
                            r_wstrb <= bus.d_wstrb_i;
                        end
                        r_state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // No timeout here: the request is held until accepted.
                    if (bus.mem_ready_i) begin
                        r_cnt   <= '0;
                        r_state <= ARB_WAIT_RESP;
                    end
                end
                ARB_WAIT_RESP: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_resp_fire) begin
                        // Only the owner's read-data/error registers change,
                        // so the other requester keeps its previous value.
                        if (r_owner == OWNER_FETCH) begin
                            r_f_rvalid <= 1'b1;
                            r_f_rdata  <= w_resp_data;
                            r_f_err    <= w_resp_err;
                        end else begin
                            r_d_rvalid <= 1'b1;
                            r_d_rdata  <= w_resp_data;
                            r_d_err    <= w_resp_err;
                        end
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.f_gnt_o     = w_grant && (w_winner == OWNER_FETCH);
    assign bus.d_gnt_o     = w_grant && (w_winner == OWNER_DATA);
    assign bus.f_rvalid_o  = r_f_rvalid;
    assign bus.f_rdata_o   = r_f_rdata;
    assign bus.f_err_o     = r_f_err;
    assign bus.d_rvalid_o  = r_d_rvalid;
    assign bus.d_rdata_o   = r_d_rdata;
    assign bus.d_err_o     = r_d_err;
    assign bus.mem_valid_o = (r_state == ARB_ISSUE);
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_we_o    = r_we;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_wstrb_o = r_wstrb;
    assign bus.busy_o      = (r_state != ARB_IDLE);

endmodule : mem_port_arbiter
`default_nettype wire
